instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader_pkg.sv | 79 +++++++
 rtl/instr_loader_encoder.sv | 63 ++++++
 rtl/instr_loader.sv | 153 +++++++++++++++
 tb/tb_instr_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_loader_pkg.sv
// ============================================================================
// Module   : instr_loader_pkg
// Purpose  : ISA constants, field positions and format classification shared
//            by the instruction encoder and the loader control logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_loader_pkg;

    localparam int c_REG_W  = 5;
    localparam int c_IMM_W  = 17;
    localparam int c_TGT_W  = 27;
    localparam int c_WORD_W = 32;
    localparam int c_ADDR_W = 12;
    localparam int c_CNT_W  = 13;

    localparam logic [c_ADDR_W-1:0] c_ADDR_MAX = '1;

    // Opcodes
    localparam logic [c_REG_W-1:0] c_OP_RTYPE = 5'b00000;
    localparam logic [c_REG_W-1:0] c_OP_ADDI  = 5'b00101;
    localparam logic [c_REG_W-1:0] c_OP_SW    = 5'b00111;
    localparam logic [c_REG_W-1:0] c_OP_LW    = 5'b01000;
    localparam logic [c_REG_W-1:0] c_OP_BNE   = 5'b00010;
    localparam logic [c_REG_W-1:0] c_OP_BLT   = 5'b00110;
    localparam logic [c_REG_W-1:0] c_OP_J     = 5'b00001;
    localparam logic [c_REG_W-1:0] c_OP_JAL   = 5'b00011;
    localparam logic [c_REG_W-1:0] c_OP_BEX   = 5'b10110;
    localparam logic [c_REG_W-1:0] c_OP_SETX  = 5'b10101;
    localparam logic [c_REG_W-1:0] c_OP_JR    = 5'b00100;

    // Field bit positions within the 32-bit word
    localparam int c_OPC_MSB   = 31;
    localparam int c_OPC_LSB   = 27;
    localparam int c_RD_MSB    = 26;
    localparam int c_RD_LSB    = 22;
    localparam int c_RS_MSB    = 21;
    localparam int c_RS_LSB    = 17;
    localparam int c_RT_MSB    = 16;
    localparam int c_RT_LSB    = 12;
    localparam int c_SHAMT_MSB = 11;
    localparam int c_SHAMT_LSB = 7;
    localparam int c_ALUOP_MSB = 6;
    localparam int c_ALUOP_LSB = 2;
    localparam int c_IMM_MSB   = 16;
    localparam int c_IMM_LSB   = 0;
    localparam int c_TGT_MSB   = 26;
    localparam int c_TGT_LSB   = 0;

    // Loader FSM encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCEPT = 2'd1;
    localparam logic [1:0] c_ST_WRITE  = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_JI  = 3'd2,
        FMT_JII = 3'd3,
        FMT_INV = 3'd4
    } fmt_e;

    function automatic fmt_e classify(input logic [c_REG_W-1:0] op);
        fmt_e fmt;
        case (op)
            c_OP_RTYPE:                                   fmt = FMT_R;
            c_OP_ADDI, c_OP_SW, c_OP_LW, c_OP_BNE, c_OP_BLT: fmt = FMT_I;
            c_OP_J, c_OP_JAL, c_OP_BEX, c_OP_SETX:         fmt = FMT_JI;
            c_OP_JR:                                      fmt = FMT_JII;
            default:                                      fmt = FMT_INV;
        endcase
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/instr_loader_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Combinational packer turning instruction fields into a 32-bit
//            word; o_valid is low for opcodes outside the ISA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder
    import instr_loader_pkg::*;
(
    input  logic [c_REG_W-1:0]  i_opcode,
    input  logic [c_REG_W-1:0]  i_rd,
    input  logic [c_REG_W-1:0]  i_rs,
    input  logic [c_REG_W-1:0]  i_rt,
    input  logic [c_REG_W-1:0]  i_shamt,
    input  logic [c_REG_W-1:0]  i_aluop,
    input  logic [c_IMM_W-1:0]  i_imm,
    input  logic [c_TGT_W-1:0]  i_target,
    output logic [c_WORD_W-1:0] o_word,
    output logic                o_valid
);

    fmt_e w_fmt;

    assign w_fmt = classify(i_opcode);

    // Start from all-zero so every region a format leaves unused is forced low
    always_comb begin
        o_word  = '0;
        o_valid = 1'b1;
        case (w_fmt)
            FMT_R: begin
                o_word[c_OPC_MSB:c_OPC_LSB]     = i_opcode;
                o_word[c_RD_MSB:c_RD_LSB]       = i_rd;
                o_word[c_RS_MSB:c_RS_LSB]       = i_rs;
                o_word[c_RT_MSB:c_RT_LSB]       = i_rt;
                o_word[c_SHAMT_MSB:c_SHAMT_LSB] = i_shamt;
                o_word[c_ALUOP_MSB:c_ALUOP_LSB] = i_aluop;
            end
            FMT_I: begin
                o_word[c_OPC_MSB:c_OPC_LSB] = i_opcode;
                o_word[c_RD_MSB:c_RD_LSB]   = i_rd;
                o_word[c_RS_MSB:c_RS_LSB]   = i_rs;
                o_word[c_IMM_MSB:c_IMM_LSB] = i_imm;
            end
            FMT_JI: begin
                o_word[c_OPC_MSB:c_OPC_LSB] = i_opcode;
                o_word[c_TGT_MSB:c_TGT_LSB] = i_target;
            end
            FMT_JII: begin
                o_word[c_OPC_MSB:c_OPC_LSB] = i_opcode;
                o_word[c_RD_MSB:c_RD_LSB]   = i_rd;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
// Module   : instr_loader
// Purpose  : Accepts instruction fields over a valid/ready handshake, encodes
//            them and writes one word per two cycles into instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_loader
    import instr_loader_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [c_REG_W-1:0]  in_opcode,
    input  logic [c_REG_W-1:0]  in_rd,
    input  logic [c_REG_W-1:0]  in_rs,
    input  logic [c_REG_W-1:0]  in_rt,
    input  logic [c_REG_W-1:0]  in_shamt,
    input  logic [c_REG_W-1:0]  in_aluop,
    input  logic [c_IMM_W-1:0]  in_imm,
    input  logic [c_TGT_W-1:0]  in_target,
    input  logic                in_last,
    output logic                imem_we,
    output logic [c_ADDR_W-1:0] imem_addr,
    output logic [c_WORD_W-1:0] imem_data,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [c_CNT_W-1:0]  count
);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_WORD_W-1:0] r_word;
    logic                r_last;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_err;
    logic [c_WORD_W-1:0] w_enc_word;
    logic                w_enc_valid;
    logic                w_end_session;

    instr_encoder u_encoder (
        .i_opcode (in_opcode),
        .i_rd     (in_rd),
        .i_rs     (in_rs),
        .i_rt     (in_rt),
        .i_shamt  (in_shamt),
        .i_aluop  (in_aluop),
        .i_imm    (in_imm),
        .i_target (in_target),
        .o_word   (w_enc_word),
        .o_valid  (w_enc_valid)
    );

    // The top address ends the session rather than wrapping to 0
    assign w_end_session = r_last || (r_addr == c_ADDR_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        imem_we      = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next_state = c_ST_ACCEPT;
                end
            end
            c_ST_ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (w_enc_valid) begin
                        w_next_state = c_ST_WRITE;
                    end else if (in_last) begin
                        w_next_state = c_ST_DONE;
                    end
                end
            end
            c_ST_WRITE: begin
                imem_we      = 1'b1;
                w_next_state = w_end_session ? c_ST_DONE : c_ST_ACCEPT;
            end
            c_ST_DONE: begin
                done         = 1'b1;
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_word  <= '0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                c_ST_ACCEPT: begin
                    if (in_valid) begin
                        if (w_enc_valid) begin
                            r_word <= w_enc_word;
                            r_last <= in_last;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_WRITE: begin
                    r_count <= r_count + 1'b1;
                    if (!w_end_session) begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr = r_addr;
    assign imem_data = r_word;
    assign err       = r_err;
    assign count     = r_count;

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
// Module   : tb_instr_loader
// Purpose  : Directed self-checking bench with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_loader;

    logic        clock;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_shamt;
    logic [4:0]  in_aluop;
    logic [16:0] in_imm;
    logic [26:0] in_target;
    logic        in_last;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [12:0] count;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t q_exp[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    instr_loader dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_shamt  (in_shamt),
        .in_aluop  (in_aluop),
        .in_imm    (in_imm),
        .in_target (in_target),
        .in_last   (in_last),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected entry
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            check("write_expected", {31'd0, q_exp.size() > 0}, 32'd1);
            if (q_exp.size() > 0) begin
                exp_t e;
                e = q_exp.pop_front();
                check("write_addr", {20'd0, imem_addr}, {20'd0, e.addr});
                check("write_data", imem_data, e.data);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] sh, input logic [4:0] alu,
                        input logic [16:0] imm, input logic [26:0] tgt, input logic last,
                        input int bound, output logic acc);
        in_opcode = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_shamt  = sh;
        in_aluop  = alu;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
        in_valid  = 1'b1;
        acc       = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (in_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (acc) begin
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
        @(negedge clock);
        check({tag, "_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    {31'd0, imem_we},  32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},     32'd0);
        check({tag, "_done"},  {31'd0, done},     32'd0);
        check({tag, "_err"},   {31'd0, err},      32'd0);
        check({tag, "_count"}, {19'd0, count},    32'd0);
        check({tag, "_addr"},  {20'd0, imem_addr}, 32'd0);
        check({tag, "_data"},  imem_data,         32'd0);
    endtask

    initial begin
        logic acc;
        logic saw_ready;
        logic saw_done;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_shamt = '0;
        in_aluop = '0; in_imm = '0; in_target = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // addi rd=1 rs=0 imm=5, last
        do_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        q_exp.push_back('{addr: 12'd0, data: 32'h2840_0005});
        send(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b1, 20, acc);
        check("addi_acc", {31'd0, acc}, 32'd1);
        check("addi_we_latency", {31'd0, imem_we}, 32'd1);
        wait_done("addi_done");
        check("addi_count", {19'd0, count}, 32'd1);

        // R-type sub, stray start mid-session, then j with last
        do_start();
        q_exp.push_back('{addr: 12'd0, data: 32'h00C2_2004});
        send(5'b00000, 5'd3, 5'd1, 5'd2, 5'd0, 5'd1, 17'h1FFFF, 27'h7FFFFFF, 1'b0, 20, acc);
        check("rtype_acc", {31'd0, acc}, 32'd1);
        check("write_not_ready", {31'd0, in_ready}, 32'd0);
        do_start();
        q_exp.push_back('{addr: 12'd1, data: 32'h0800_0064});
        send(5'b00001, 5'd7, 5'd7, 5'd7, 5'd7, 5'd7, 17'h1FFFF, 27'd100, 1'b1, 20, acc);
        check("j_acc", {31'd0, acc}, 32'd1);
        wait_done("rj_done");
        check("rj_count", {19'd0, count}, 32'd2);

        // jr rd=31 with garbage fields
        do_start();
        q_exp.push_back('{addr: 12'd0, data: 32'h27C0_0000});
        send(5'b00100, 5'd31, 5'h15, 5'd7, 5'd9, 5'd3, 17'h1ABCD, 27'h5555555, 1'b1, 20, acc);
        wait_done("jr_done");
        check("jr_count", {19'd0, count}, 32'd1);

        // invalid opcode dropped, then addi with last
        do_start();
        send(5'b11111, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 17'd1, 27'd1, 1'b0, 20, acc);
        check("inv_acc", {31'd0, acc}, 32'd1);
        check("inv_no_write", {31'd0, imem_we}, 32'd0);
        check("inv_err", {31'd0, err}, 32'd1);
        q_exp.push_back('{addr: 12'd0, data: 32'h2840_0005});
        send(5'b00101, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'd5, 27'd0, 1'b1, 20, acc);
        wait_done("inv_done");
        check("inv_count", {19'd0, count}, 32'd1);
        repeat (3) @(negedge clock);
        check("err_sticky", {31'd0, err}, 32'd1);
        do_start();
        check("err_cleared", {31'd0, err}, 32'd0);

        // reset during WRITE
        q_exp.push_back('{addr: 12'd0, data: {5'b00101, 5'd2, 5'd0, 17'd7}});
        send(5'b00101, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 17'd7, 27'd0, 1'b0, 20, acc);
        check("rst_in_write", {31'd0, imem_we}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        do_start();
        q_exp.push_back('{addr: 12'd0, data: {5'b00101, 5'd4, 5'd0, 17'd9}});
        send(5'b00101, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 17'd9, 27'd0, 1'b1, 20, acc);
        wait_done("restart_done");
        check("restart_count", {19'd0, count}, 32'd1);

        // 4096-word stream without last; 4097th must not be accepted
        do_start();
        for (int i = 0; i < 4096; i++) begin
            logic [16:0] imm;
            logic [4:0]  rd;
            imm = 17'(i);
            rd  = 5'(i);
            q_exp.push_back('{addr: 12'(i), data: {5'b00101, rd, ~rd, imm}});
            send(5'b00101, rd, ~rd, 5'd0, 5'd0, 5'd0, imm, 27'd0, 1'b0, 20, acc);
            if (!acc) check("stream_acc", {31'd0, acc}, 32'd1);
        end
        in_opcode = 5'b00101; in_imm = 17'd4096; in_valid = 1'b1; in_last = 1'b0;
        saw_ready = 1'b0;
        saw_done  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (in_ready) saw_ready = 1'b1;
            if (done) saw_done = 1'b1;
        end
        in_valid = 1'b0;
        check("stream_4097_refused", {31'd0, saw_ready}, 32'd0);
        check("stream_done", {31'd0, saw_done}, 32'd1);
        check("stream_count", {19'd0, count}, 32'd4096);
        check("stream_last_addr", {20'd0, imem_addr}, 32'd4095);

        repeat (3) @(negedge clock);
        check("scoreboard_drained", q_exp.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
